rsa_mac_ctrl: RTL and testbench

- Sequencer for a ROWS x COLS systolic array of PE_MAC cells.
- On start it performs one matrix product C = A * B with inner dimension k_len.
- It generates skewed operand-buffer reads, per-column cal_en/cal_done at the array's north edge, and a stable PE_mode.
- It collects results from the west edge, tagging each with its column index, and signals completion.

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rsa_row_collector.sv | 40 ++++
 rtl/rsa_mac_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rsa_mac_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared encodings for the systolic-array sequencer: FSM states and PE mode values.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_W2E_N2S = 2'b00;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rsa_row_collector.sv
// One west-edge row: registers each arriving result and tags it with the next column index.
module rsa_row_collector #(
    parameter int RSA_DW = 16,
    parameter int K_W    = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              clear,
    input  logic              accept_en,
    input  logic              mulres_val,
    input  logic [RSA_DW-1:0] mulres,
    output logic              res_val,
    output logic [K_W-1:0]    res_col,
    output logic [RSA_DW-1:0] res_data,
    output logic              accepted
);

    logic [K_W-1:0] col;

    assign accepted = accept_en & mulres_val;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col      <= '0;
            res_val  <= 1'b0;
            res_col  <= '0;
            res_data <= '0;
        end else begin
            res_val <= accepted;
            if (clear) begin
                col <= '0;
            end else if (accepted) begin
                col      <= col + K_W'(1);
                res_col  <= col;
                res_data <= mulres;
            end
        end
    end

endmodule

// File: rtl/rsa_mac_ctrl.sv
// Sequencer for a ROWS x COLS PE_MAC array: skewed buffer reads, north-edge calc
// control, west-edge result collection and job completion.
//
// state | meaning
// IDLE  | waiting for start; PE_mode holds the last job's mode
// FEED  | cnt advances; reads and cal_en/cal_done issued from cnt
// DRAIN | feeding finished; waiting for the remaining results
// DONE  | one cycle, done pulse
module rsa_mac_ctrl
    import rsa_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int RSA_DW = 16,
    parameter int K_W    = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic [1:0]             mode_i,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ROWS-1:0]        h_rd_en,
    output logic [ROWS*K_W-1:0]    h_rd_addr,
    output logic [COLS-1:0]        v_rd_en,
    output logic [COLS*K_W-1:0]    v_rd_addr,
    output logic [COLS-1:0]        cal_en_N,
    output logic [COLS-1:0]        cal_done_N,
    output logic [1:0]             PE_mode,
    input  logic [ROWS-1:0]        mulres_val_W,
    input  logic [ROWS*RSA_DW-1:0] mulres_W,
    output logic [ROWS-1:0]        res_val,
    output logic [ROWS*K_W-1:0]    res_col,
    output logic [ROWS*RSA_DW-1:0] res_data
);

    localparam int FEED_EXTRA = max2(ROWS - 2, COLS);
    localparam int CNT_MAX    = (2**K_W - 1) + max2(ROWS, COLS) + 2;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int TOT        = ROWS * COLS;
    localparam int TOT_W      = $clog2(2 * TOT + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, k_nx, feed_last;
    logic [K_W-1:0]     k_q;
    logic [TOT_W-1:0]   total, acc_sum;
    logic [ROWS-1:0]    accepted;
    logic               job_start, err_nx, all_in, collect_en, feed_nx;

    logic [ROWS-1:0]     h_en_nx;
    logic [ROWS*K_W-1:0] h_addr_nx;
    logic [COLS-1:0]     v_en_nx, cal_en_nx, cal_done_nx;
    logic [COLS*K_W-1:0] v_addr_nx;

    assign collect_en = (state == FEED) || (state == DRAIN);
    assign feed_last  = CNT_W'(FEED_EXTRA) + CNT_W'(k_q);

    always_comb begin
        acc_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc_sum = acc_sum + TOT_W'(accepted[r]);
        end
    end

    // Looks ahead by one cycle's acceptances so done lands right after the last result strobe.
    assign all_in = ((total + acc_sum) == TOT_W'(TOT));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        job_start = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_nx  = FEED;
                        cnt_nx    = '0;
                        job_start = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            FEED: begin
                cnt_nx = cnt + CNT_W'(1);
                if (all_in)
                    state_nx = DONE;
                else if (cnt == feed_last)
                    state_nx = DRAIN;
            end
            DRAIN: if (all_in) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Array-edge signals are decoded from next state/cnt so the registered copies line up with cnt.
    always_comb begin
        k_nx        = job_start ? CNT_W'(k_len) : CNT_W'(k_q);
        feed_nx     = (state_nx == FEED);
        h_en_nx     = '0;
        h_addr_nx   = '0;
        v_en_nx     = '0;
        v_addr_nx   = '0;
        cal_en_nx   = '0;
        cal_done_nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (feed_nx && cnt_nx >= CNT_W'(r) && cnt_nx < CNT_W'(r) + k_nx) begin
                h_en_nx[r]               = 1'b1;
                h_addr_nx[r*K_W +: K_W]  = K_W'(cnt_nx - CNT_W'(r));
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (feed_nx && cnt_nx >= CNT_W'(c) && cnt_nx < CNT_W'(c) + k_nx) begin
                v_en_nx[c]               = 1'b1;
                v_addr_nx[c*K_W +: K_W]  = K_W'(cnt_nx - CNT_W'(c));
            end
            cal_en_nx[c]   = feed_nx && (cnt_nx >= CNT_W'(c + 1)) && (cnt_nx <= CNT_W'(c) + k_nx);
            cal_done_nx[c] = feed_nx && (cnt_nx == CNT_W'(c + 1) + k_nx);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            k_q        <= '0;
            total      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            PE_mode    <= MODE_W2E_N2S;
            h_rd_en    <= '0;
            h_rd_addr  <= '0;
            v_rd_en    <= '0;
            v_rd_addr  <= '0;
            cal_en_N   <= '0;
            cal_done_N <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            err        <= err_nx;
            h_rd_en    <= h_en_nx;
            h_rd_addr  <= h_addr_nx;
            v_rd_en    <= v_en_nx;
            v_rd_addr  <= v_addr_nx;
            cal_en_N   <= cal_en_nx;
            cal_done_N <= cal_done_nx;
            if (job_start) begin
                k_q     <= k_len;
                PE_mode <= mode_i;
                total   <= '0;
            end else if (collect_en) begin
                total <= total + acc_sum;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        rsa_row_collector #(
            .RSA_DW (RSA_DW),
            .K_W    (K_W)
        ) u_collector (
            .clk        (clk),
            .sys_rst_n  (sys_rst_n),
            .clear      (job_start),
            .accept_en  (collect_en),
            .mulres_val (mulres_val_W[r]),
            .mulres     (mulres_W[r*RSA_DW +: RSA_DW]),
            .res_val    (res_val[r]),
            .res_col    (res_col[r*K_W +: K_W]),
            .res_data   (res_data[r*RSA_DW +: RSA_DW]),
            .accepted   (accepted[r])
        );
    end

endmodule

// File: tb/tb_rsa_mac_ctrl.sv
// Directed bench for rsa_mac_ctrl on a 2x2 array with a behavioural buffer/array model.
module tb_rsa_mac_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 16;
    localparam int KW   = 8;

    logic                 clk;
    logic                 sys_rst_n;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic [1:0]           mode_i;
    logic                 busy, done, err;
    logic [ROWS-1:0]      h_rd_en;
    logic [ROWS*KW-1:0]   h_rd_addr;
    logic [COLS-1:0]      v_rd_en;
    logic [COLS*KW-1:0]   v_rd_addr;
    logic [COLS-1:0]      cal_en_N, cal_done_N;
    logic [1:0]           PE_mode;
    logic [ROWS-1:0]      mulres_val_W;
    logic [ROWS*DW-1:0]   mulres_W;
    logic [ROWS-1:0]      res_val;
    logic [ROWS*KW-1:0]   res_col;
    logic [ROWS*DW-1:0]   res_data;

    rsa_mac_ctrl #(.ROWS(ROWS), .COLS(COLS), .RSA_DW(DW), .K_W(KW)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .k_len        (k_len),
        .mode_i       (mode_i),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .h_rd_en      (h_rd_en),
        .h_rd_addr    (h_rd_addr),
        .v_rd_en      (v_rd_en),
        .v_rd_addr    (v_rd_addr),
        .cal_en_N     (cal_en_N),
        .cal_done_N   (cal_done_N),
        .PE_mode      (PE_mode),
        .mulres_val_W (mulres_val_W),
        .mulres_W     (mulres_W),
        .res_val      (res_val),
        .res_col      (res_col),
        .res_data     (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int A [ROWS][8];
    int B [8][COLS];
    int a_seen [ROWS][8];
    int b_seen [8][COLS];
    int got [ROWS][COLS];
    int got_n, bad_col, done_cnt, done_fc, cur_k, fc;
    logic busy_q;

    // Array model: captures operands the DUT actually reads, returns dot products at r+2c+K+2.
    initial begin
        int idx, s, col;
        fc = 0; busy_q = 1'b0; cur_k = 1;
        got_n = 0; bad_col = 0; done_cnt = 0; done_fc = -1;
        mulres_val_W = '0; mulres_W = '0;
        forever begin
            @(negedge clk);
            if (busy && !busy_q) begin
                fc = 0;
                for (int r = 0; r < ROWS; r++) for (int k = 0; k < 8; k++) a_seen[r][k] = 0;
                for (int k = 0; k < 8; k++) for (int c = 0; c < COLS; c++) b_seen[k][c] = 0;
            end else if (busy) begin
                fc++;
            end
            busy_q = busy;
            mulres_val_W = '0;
            mulres_W = '0;
            if (busy) begin
                for (int r = 0; r < ROWS; r++) begin
                    idx = int'(h_rd_addr[r*KW +: KW]);
                    if (h_rd_en[r] && idx < 8) a_seen[r][idx] = A[r][idx];
                end
                for (int c = 0; c < COLS; c++) begin
                    idx = int'(v_rd_addr[c*KW +: KW]);
                    if (v_rd_en[c] && idx < 8) b_seen[idx][c] = B[idx][c];
                end
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (fc == r + 2*c + cur_k + 2) begin
                            s = 0;
                            for (int k = 0; k < cur_k; k++) s += a_seen[r][k] * b_seen[k][c];
                            mulres_val_W[r] = 1'b1;
                            mulres_W[r*DW +: DW] = s[DW-1:0];
                        end
                    end
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (res_val[r]) begin
                    col = int'(res_col[r*KW +: KW]);
                    if (col < COLS) got[r][col] = int'(res_data[r*DW +: DW]);
                    else bad_col++;
                    got_n++;
                end
            end
            if (done) begin
                done_cnt++;
                done_fc = fc;
            end
        end
    end

    task automatic launch(input int k, input logic [1:0] m);
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) got[r][c] = -1;
        got_n = 0; bad_col = 0; done_cnt = 0; done_fc = -1; cur_k = k;
        start = 1'b1; k_len = KW'(k); mode_i = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_ab_2x2();
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; start = 1'b0; k_len = '0; mode_i = 2'b00;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, err, h_rd_en, v_rd_en, cal_en_N, cal_done_N, PE_mode, res_val} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h expected 0",
                     {busy, done, err, h_rd_en, v_rd_en, cal_en_N, cal_done_N, PE_mode, res_val});
        end
        n_tests++;
        if ({h_rd_addr, v_rd_addr, res_col, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h expected 0", {h_rd_addr, v_rd_addr, res_col, res_data});
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, err, h_rd_en, v_rd_en} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_release: got %0h expected 0", {busy, done, err, h_rd_en, v_rd_en});
        end
    endtask

    task automatic test_product_k2();
        logic [1:0]  exp_en [4]   = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [15:0] exp_addr [4] = '{16'h0000, 16'h0001, 16'h0100, 16'h0000};
        int exp_c [2][2] = '{'{19, 22}, '{43, 50}};
        bit seen;
        set_ab_2x2();
        @(negedge clk);
        launch(2, 2'b00);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({h_rd_en, v_rd_en, h_rd_addr, v_rd_addr} !== {exp_en[i], exp_en[i], exp_addr[i], exp_addr[i]}) begin
                n_fail++;
                $display("FAIL k2_reads fc%0d: got %0h expected %0h", i,
                         {h_rd_en, v_rd_en, h_rd_addr, v_rd_addr}, {exp_en[i], exp_en[i], exp_addr[i], exp_addr[i]});
            end
            @(negedge clk);
        end
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL k2_done_timeout: got no done expected done"); end
        @(negedge clk);
        n_tests++;
        if (done_fc !== 8) begin n_fail++; $display("FAIL k2_done_fc: got %0d expected 8", done_fc); end
        n_tests++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL k2_idle_after: got %b expected 00", {busy, done}); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp_c[r][c]) begin
                n_fail++;
                $display("FAIL k2_res r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp_c[r][c]);
            end
        end
        n_tests++;
        if (got_n !== 4 || bad_col !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL k2_counts: got n=%0d bad=%0d done=%0d expected 4 0 1", got_n, bad_col, done_cnt);
        end
    endtask

    task automatic test_cal_k1();
        // {h_rd_en, v_rd_en, cal_en_N, cal_done_N}
        logic [7:0] exp_w [5] = '{8'b01010000, 8'b10100100, 8'b00001001, 8'b00000010, 8'b00000000};
        int exp_c [2][2] = '{'{8, 10}, '{12, 15}};
        bit seen;
        A[0][0] = 2; A[1][0] = 3; B[0][0] = 4; B[0][1] = 5;
        @(negedge clk);
        launch(1, 2'b10);
        n_tests++;
        if (PE_mode !== 2'b10) begin n_fail++; $display("FAIL k1_mode: got %b expected 10", PE_mode); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({h_rd_en, v_rd_en, cal_en_N, cal_done_N} !== exp_w[i]) begin
                n_fail++;
                $display("FAIL k1_wave fc%0d: got %b expected %b", i,
                         {h_rd_en, v_rd_en, cal_en_N, cal_done_N}, exp_w[i]);
            end
            @(negedge clk);
        end
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL k1_done_timeout: got no done expected done"); end
        @(negedge clk);
        n_tests++;
        if (done_fc !== 7) begin n_fail++; $display("FAIL k1_done_fc: got %0d expected 7", done_fc); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp_c[r][c]) begin
                n_fail++;
                $display("FAIL k1_res r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp_c[r][c]);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({busy, PE_mode} !== 3'b010) begin
            n_fail++;
            $display("FAIL k1_mode_hold: got %b expected 010", {busy, PE_mode});
        end
    endtask

    task automatic test_err();
        logic [3:0] rd_seen = '0;
        @(negedge clk);
        start = 1'b1; k_len = '0;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL err_pulse: got %b expected 10", {err, busy}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_seen = rd_seen | {h_rd_en, v_rd_en};
        end
        n_tests++;
        if ({err, busy, rd_seen} !== 6'b000000) begin
            n_fail++;
            $display("FAIL err_after: got %b expected 000000", {err, busy, rd_seen});
        end
    endtask

    task automatic test_ignored_start();
        int exp_c [2][2] = '{'{19, 22}, '{43, 50}};
        bit seen;
        set_ab_2x2();
        @(negedge clk);
        launch(2, 2'b00);
        @(negedge clk);
        start = 1'b1; k_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL ign_done_timeout: got no done expected done"); end
        @(negedge clk);
        n_tests++;
        if (done_fc !== 8) begin n_fail++; $display("FAIL ign_done_fc: got %0d expected 8", done_fc); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp_c[r][c]) begin
                n_fail++;
                $display("FAIL ign_res r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp_c[r][c]);
            end
        end
        n_tests++;
        if (got_n !== 4) begin n_fail++; $display("FAIL ign_count: got %0d expected 4", got_n); end
    endtask

    task automatic test_reset_mid_drain();
        int exp_c [2][2] = '{'{19, 22}, '{43, 50}};
        bit seen;
        set_ab_2x2();
        @(negedge clk);
        launch(2, 2'b01);
        repeat (5) @(negedge clk);
        n_tests++;
        if ({busy, PE_mode} !== 3'b101) begin
            n_fail++;
            $display("FAIL rst_pre: got %b expected 101", {busy, PE_mode});
        end
        #2 sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, err, h_rd_en, v_rd_en, cal_en_N, cal_done_N, PE_mode, res_val, res_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got %0h expected 0",
                     {busy, done, err, h_rd_en, v_rd_en, cal_en_N, cal_done_N, PE_mode, res_val, res_data});
        end
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got done=%0d busy=%b expected 0 0", done_cnt, busy);
        end
        launch(2, 2'b00);
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rst_job_timeout: got no done expected done"); end
        @(negedge clk);
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp_c[r][c]) begin
                n_fail++;
                $display("FAIL rst_res r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp_c[r][c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp1 [2][2] = '{'{22, 28}, '{49, 64}};
        int exp2 [2][2] = '{'{19, 22}, '{43, 50}};
        bit seen;
        A[0][0] = 1; A[0][1] = 2; A[0][2] = 3; A[1][0] = 4; A[1][1] = 5; A[1][2] = 6;
        B[0][0] = 1; B[0][1] = 2; B[1][0] = 3; B[1][1] = 4; B[2][0] = 5; B[2][1] = 6;
        @(negedge clk);
        launch(3, 2'b00);
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL b2b_first_timeout: got no done expected done"); end
        @(negedge clk);
        n_tests++;
        if (done_fc !== 9) begin n_fail++; $display("FAIL b2b_first_fc: got %0d expected 9", done_fc); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp1[r][c]) begin
                n_fail++;
                $display("FAIL b2b_first r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp1[r][c]);
            end
        end
        set_ab_2x2();
        for (int k = 2; k < 8; k++) begin A[0][k] = 0; A[1][k] = 0; B[k][0] = 0; B[k][1] = 0; end
        launch(2, 2'b00);
        wait_done(seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL b2b_second_timeout: got no done expected done"); end
        @(negedge clk);
        n_tests++;
        if (done_fc !== 8) begin n_fail++; $display("FAIL b2b_second_fc: got %0d expected 8", done_fc); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            n_tests++;
            if (got[r][c] !== exp2[r][c]) begin
                n_fail++;
                $display("FAIL b2b_second r%0d c%0d: got %0d expected %0d", r, c, got[r][c], exp2[r][c]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) for (int k = 0; k < 8; k++) A[r][k] = 0;
        for (int k = 0; k < 8; k++) for (int c = 0; c < COLS; c++) B[k][c] = 0;
        test_reset();
        test_product_k2();
        test_cal_k1();
        test_err();
        test_ignored_start();
        test_reset_mid_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
